// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle for branch_resolve_unit: branch operands in, resolved result out.
// master = producer/consumer side, slave = the resolve stage.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm;
    logic            pred_taken_in;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal;

    modport master (
        output in_valid, pc, A, B, func3, imm, pred_taken_in, out_ready,
        input  in_ready, out_valid, taken, mispredict, redirect_pc, illegal
    );

    modport slave (
        input  in_valid, pc, A, B, func3, imm, pred_taken_in, out_ready,
        output in_ready, out_valid, taken, mispredict, redirect_pc, illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// RV32I branch resolve stage with registered, back-pressurable result and 2-bit BHT.
// Define BRANCH_RESOLVE_BHT_EN to build the branch history table; otherwise lookups predict not-taken.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [XLEN-1:0]      lookup_pc,
    output logic                 lookup_taken,
    output logic [31:0]          mispred_cnt,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q, state_d;
    logic            taken_q, taken_d;
    logic            mispredict_q, mispredict_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     mispred_cnt_q, mispred_cnt_d;

    logic            in_ready;
    logic            accept;
    logic            res_taken;
    logic            res_illegal;
    logic            res_mispredict;
    logic [XLEN-1:0] res_redirect;
    logic            unused_lookup;

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        unique case (bus.func3)
            3'b000:  res_taken = (bus.A == bus.B);
            3'b001:  res_taken = (bus.A != bus.B);
            3'b100:  res_taken = ($signed(bus.A) <  $signed(bus.B));
            3'b101:  res_taken = ($signed(bus.A) >= $signed(bus.B));
            3'b110:  res_taken = (bus.A <  bus.B);
            3'b111:  res_taken = (bus.A >= bus.B);
            default: res_illegal = 1'b1;
        endcase
        res_mispredict = !res_illegal && (res_taken != bus.pred_taken_in);
        res_redirect   = res_taken ? (bus.pc + bus.imm) : (bus.pc + XLEN'(4));
    end

    assign in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !flush;

    always_comb begin
        state_d       = state_q;
        taken_d       = taken_q;
        mispredict_d  = mispredict_q;
        illegal_d     = illegal_q;
        redirect_pc_d = redirect_pc_q;
        mispred_cnt_d = mispred_cnt_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d       = FULL;
            taken_d       = res_taken;
            mispredict_d  = res_mispredict;
            illegal_d     = res_illegal;
            redirect_pc_d = res_redirect;
            if (res_mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            illegal_q     <= illegal_d;
            redirect_pc_q <= redirect_pc_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == FULL);
    assign bus.taken       = taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.illegal     = illegal_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign mispred_cnt     = mispred_cnt_q;

    // Only the index slice of lookup_pc feeds the table.
    assign unused_lookup = ^lookup_pc;

`ifdef BRANCH_RESOLVE_BHT_EN
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;

    assign upd_idx = bus.pc[IDX_W+1:2];

    // Reads the registered table, so a same-cycle update is seen only next cycle.
    assign lookup_taken = bht_q[lookup_pc[IDX_W+1:2]][1];

    always_comb begin
        bht_d = bht_q;
        if (accept && !res_illegal) begin
            if (res_taken && (bht_q[upd_idx] != 2'b11)) begin
                bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            end else if (!res_taken && (bht_q[upd_idx] != 2'b00)) begin
                bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            bht_q <= bht_d;
        end
    end
`else
    logic [IDX_W-1:0] unused_idx;

    assign unused_idx   = lookup_pc[IDX_W+1:2];
    assign lookup_taken = 1'b0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; expectations follow BRANCH_RESOLVE_BHT_EN.
module tb_branch_resolve_unit;
`ifdef BRANCH_RESOLVE_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] mispred_cnt;
    int          tests  = 0;
    int          failed = 0;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .mispred_cnt  (mispred_cnt),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [31:0] im, input logic pr);
        bus.pc            = p;
        bus.A             = a;
        bus.B             = b;
        bus.func3         = f3;
        bus.imm           = im;
        bus.pred_taken_in = pr;
        bus.in_valid      = 1'b1;
    endtask

    task automatic chk_res(input string tag, input logic tk, input logic mp,
                           input logic il, input logic [31:0] rpc);
        chk({tag, "_valid"},    {31'd0, bus.out_valid},  32'd1);
        chk({tag, "_taken"},    {31'd0, bus.taken},      {31'd0, tk});
        chk({tag, "_mispred"},  {31'd0, bus.mispredict}, {31'd0, mp});
        chk({tag, "_illegal"},  {31'd0, bus.illegal},    {31'd0, il});
        chk({tag, "_redirect"}, bus.redirect_pc,         rpc);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lookup_pc = 32'h40;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.pc = '0; bus.A = '0; bus.B = '0; bus.func3 = '0; bus.imm = '0; bus.pred_taken_in = 1'b0;
        step();
        step();
        chk("rst_valid",    {31'd0, bus.out_valid},  32'd0);
        chk("rst_taken",    {31'd0, bus.taken},      32'd0);
        chk("rst_mispred",  {31'd0, bus.mispredict}, 32'd0);
        chk("rst_illegal",  {31'd0, bus.illegal},    32'd0);
        chk("rst_redirect", bus.redirect_pc,         32'h0);
        chk("rst_cnt",      mispred_cnt,             32'd0);
        chk("rst_lookup",   {31'd0, lookup_taken},   32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready},   32'd1);

        // BEQ taken, predicted not-taken
        req(32'h100, 32'hC, 32'hC, 3'b000, 32'h20, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk_res("beq", 1'b1, 1'b1, 1'b0, 32'h120);
        chk("beq_cnt", mispred_cnt, 32'd1);
        step();
        chk("beq_drain", {31'd0, bus.out_valid}, 32'd0);

        // Signed vs unsigned compares at pc 0x208 (own table slot)
        req(32'h208, 32'hFFFF_FFFF, 32'h1, 3'b100, 32'h10, 1'b0);
        step(); bus.in_valid = 1'b0;
        chk_res("blt", 1'b1, 1'b1, 1'b0, 32'h218);
        chk("blt_cnt", mispred_cnt, 32'd2);
        step();
        req(32'h208, 32'hFFFF_FFFF, 32'h1, 3'b110, 32'h10, 1'b0);
        step(); bus.in_valid = 1'b0;
        chk_res("bltu", 1'b0, 1'b0, 1'b0, 32'h20C);
        chk("bltu_cnt", mispred_cnt, 32'd2);
        step();
        req(32'h208, 32'hFFFF_FFFF, 32'h1, 3'b111, 32'h10, 1'b0);
        step(); bus.in_valid = 1'b0;
        chk_res("bgeu", 1'b1, 1'b1, 1'b0, 32'h218);
        chk("bgeu_cnt", mispred_cnt, 32'd3);
        step();
        req(32'h208, 32'hFFFF_FFFF, 32'h1, 3'b101, 32'h10, 1'b1);
        step(); bus.in_valid = 1'b0;
        chk_res("bge", 1'b0, 1'b1, 1'b0, 32'h20C);
        chk("bge_cnt", mispred_cnt, 32'd4);
        step();
        req(32'h208, 32'h5, 32'h5, 3'b001, 32'h10, 1'b0);
        step(); bus.in_valid = 1'b0;
        chk_res("bne", 1'b0, 1'b0, 1'b0, 32'h20C);
        step();

        // Illegal func3 at pc 0x300 shares slot 0 with pc 0x100 (trained once taken)
        lookup_pc = 32'h300;
        req(32'h300, 32'h0, 32'h0, 3'b011, 32'h40, 1'b1);
        step(); bus.in_valid = 1'b0;
        chk_res("ill", 1'b0, 1'b0, 1'b1, 32'h304);
        chk("ill_cnt", mispred_cnt, 32'd4);
        chk("ill_table", {31'd0, lookup_taken}, {31'd0, BHT_ON});
        step();

        // Back-pressure: hold R1 while R2 waits
        bus.out_ready = 1'b0;
        req(32'h400, 32'h1, 32'h2, 3'b000, 32'h40, 1'b0);
        step();
        req(32'h500, 32'h1, 32'h2, 3'b001, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk_res("bp_hold", 1'b0, 1'b0, 1'b0, 32'h404);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step(); bus.in_valid = 1'b0;
        chk_res("bp_r2", 1'b1, 1'b0, 1'b0, 32'h540);
        chk("bp_cnt", mispred_cnt, 32'd4);
        step();
        chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);

        // Wrap-around target
        req(32'hFFFF_FFFC, 32'h7, 32'h7, 3'b000, 32'h8, 1'b1);
        step();
        chk_res("wrap", 1'b1, 1'b0, 1'b0, 32'h4);

        // Flush with a valid request while FULL; slot 0 currently weakly taken
        lookup_pc = 32'h40;
        flush = 1'b1;
        req(32'h40, 32'h1, 32'h1, 3'b000, 32'h8, 1'b0);
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("flush_cnt",    mispred_cnt,            32'd4);
        chk("flush_table",  {31'd0, lookup_taken},  {31'd0, BHT_ON});

        // Asynchronous reset while FULL
        req(32'h600, 32'h3, 32'h3, 3'b000, 32'h8, 1'b1);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("arst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("arst_cnt",    mispred_cnt,            32'd0);
        chk("arst_lookup", {31'd0, lookup_taken},  32'd0);
        step();
        rst = 1'b0; bus.out_ready = 1'b1;

        // Training at pc 0x40: 3 taken then 4 not-taken, streamed back to back
        req(32'h40, 32'h9, 32'h9, 3'b000, 32'h10, 1'b0);
        #1;
        chk("train_collide", {31'd0, lookup_taken}, 32'd0);
        step();
        chk("train_t1", {31'd0, lookup_taken}, {31'd0, BHT_ON});
        step();
        chk("train_t2", {31'd0, lookup_taken}, {31'd0, BHT_ON});
        step();
        chk("train_t3", {31'd0, lookup_taken}, {31'd0, BHT_ON});
        chk_res("train_t3", 1'b1, 1'b1, 1'b0, 32'h50);
        chk("train_t_cnt", mispred_cnt, 32'd3);
        req(32'h40, 32'h9, 32'h9, 3'b001, 32'h10, 1'b1);
        step();
        chk("train_n1", {31'd0, lookup_taken}, {31'd0, BHT_ON});
        step();
        chk("train_n2", {31'd0, lookup_taken}, 32'd0);
        step();
        chk("train_n3", {31'd0, lookup_taken}, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("train_n4", {31'd0, lookup_taken}, 32'd0);
        chk_res("train_n4", 1'b0, 1'b1, 1'b0, 32'h44);
        chk("train_n_cnt", mispred_cnt, 32'd7);
        step();
        chk("final_drain", {31'd0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised RV32I branch resolution stage with a registered, back-pressurable result and a built-in branch history table. It sits between decode/register-read and the fetch redirect logic. Per branch it evaluates the func3 condition on A/B, computes the redirect PC and flags a mispredict against the prediction fetch made. It also serves same-cycle prediction lookups to fetch and trains a table of 2-bit saturating counters on every resolved branch.

## Interface
- XLEN, 32, operand and PC width
- BHT_DEPTH, 16, number of 2-bit counters; power of two, ≥2
- IDX_W, $clog2(BHT_DEPTH), derived table index width (localparam)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop held result and ignore this cycle's input
- in_valid  in  1  branch request valid
- in_ready  out  1  stage can accept a request
- pc  in  XLEN  branch instruction PC
- A  in  XLEN  rs1 value
- B  in  XLEN  rs2 value
- func3  in  3  branch condition code
- imm  in  XLEN  sign-extended B-type offset
- pred_taken_in  in  1  prediction fetch used for this branch
- lookup_pc  in  XLEN  fetch PC for prediction lookup
- lookup_taken  out  1  prediction for lookup_pc (combinational)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- taken  out  1  resolved direction
- mispredict  out  1  taken != pred_taken_in
- redirect_pc  out  XLEN  correct next PC
- illegal  out  1  func3 was 010 or 011
- mispred_cnt  out  32  saturating mispredict count

## Operation
- Conditions: 000 BEQ A==B; 001 BNE A!=B; 100 BLT signed A<B; 101 BGE signed A>=B; 110 BLTU unsigned A<B; 111 BGEU unsigned A>=B.
- func3 010 or 011: taken=0, mispredict=0, illegal=1, redirect_pc=pc+4. No table update and no counter increment.
- redirect_pc = taken ? pc+imm : pc+4. Computed modulo 2^XLEN, so carry-out is discarded (wrap-around).
- Table index = pc[IDX_W+1:2], and the same slice of lookup_pc is used for lookups.
- lookup_taken = counter[msb].
- Accept happens when in_valid & in_ready & !flush. On accept:
  - the result registers load;
  - the counter at the pc index increments if taken, decrements if not taken, saturating at 3 and 0;
  - mispred_cnt increments when mispredict=1, saturating at 0xFFFFFFFF.
- Output register state: EMPTY when out_valid=0, FULL when out_valid=1.
  - EMPTY → FULL on accept.
  - FULL → EMPTY when out_ready=1 and there is no accept.
  - FULL → FULL when out_ready=1 with a same-cycle accept, or when out_ready=0 (hold).
- in_ready = !out_valid | out_ready.
- flush has priority over everything:
  - out_valid is cleared next edge;
  - the input is not accepted, so no table update and no count;
  - table contents and mispred_cnt are kept.

## Timing
- Latency is 1 cycle: a request accepted at edge N shows out_valid=1 with its result after edge N.
- Outputs hold stable while out_valid & !out_ready.
- Lookup/update collision on the same index in one cycle: lookup_taken returns the pre-update value. The new value is visible the next cycle.
- Reset values:
  - out_valid=0, taken=0, mispredict=0, illegal=0, redirect_pc=0, mispred_cnt=0;
  - all counters = 2'b01 (weakly not-taken), so lookup_taken=0.
- rst asserted mid-transaction discards any held result immediately, asynchronously.

## Configuration
- BRANCH_RESOLVE_BHT_EN defined: the counter table is present and trained as described.
- Macro undefined:
  - no table storage;
  - lookup_taken is tied 0 (static not-taken);
  - no training on accept;
  - all resolve, handshake and mispred_cnt behaviour is unchanged.

## Test plan
- Reset, then BEQ with A=B=0x0000000C, pc=0x100, imm=0x20, pred_taken_in=0 → next cycle: out_valid=1, taken=1, redirect_pc=0x120, mispredict=1, mispred_cnt=1.
- Signed vs unsigned compare, A=0xFFFFFFFF, B=1:
  - BLT → taken=1;
  - BLTU → taken=0;
  - BGEU → taken=1.
- func3=011 → illegal=1, taken=0, redirect_pc=pc+4, mispred_cnt unchanged, table unchanged.
- Back-pressure: hold out_ready=0 for 3 cycles with a new in_valid → in_ready=0, outputs frozen. Raise out_ready → the new request is accepted the same edge.
- Training (macro defined): three taken branches at pc=0x40 → lookup_taken for 0x40 goes 0→1 after the first update, then saturates. Four not-taken branches → returns to 0. A lookup in the same cycle as the first update reads 0.
- Wrap and flush:
  - pc=0xFFFFFFFC, imm=8, taken → redirect_pc=0x4.
  - flush asserted together with in_valid → out_valid=0 next cycle and the counter is unchanged.
  - rst pulsed while FULL → out_valid=0 immediately.
